ps2_kbd_rx: RTL and testbench
=============================

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FILTER_LEN, default 4, meaning consecutive identical synchronized samples required before a PS/2 line level is accepted.
REQ-002 Parameter TIMEOUT_CYC, default 50000, meaning clock cycles without a filtered PS/2 clock falling edge before a partial frame is abandoned.
REQ-003 clock  in  1  system clock (clk_sys domain); sole clock.
REQ-004 reset_osd  in  1  reset, asynchronous, active-low.
REQ-005 ps2  in  2  bit0 PS/2 clock, bit1 PS/2 data, from the hps_io keyboard outputs; asynchronous to clock.
REQ-006 code  out  8  last completed non-prefix scancode.
REQ-007 extended  out  1  E0 prefix preceded code.
REQ-008 released  out  1  F0 prefix preceded code.
REQ-009 strobe  out  1  one-cycle pulse; code/extended/released valid.
REQ-010 parity_err  out  1  one-cycle pulse on odd-parity failure.
REQ-011 frame_err  out  1  one-cycle pulse on stop bit sampled 0.
REQ-012 busy  out  1  high while the FSM is not in IDLE.

Function
REQ-013 Each ps2 bit passes a 2-flop synchronizer, then a filter updating its output only after FILTER_LEN equal consecutive samples.
REQ-014 A falling edge is filtered clock 1 in cycle n-1 and 0 in cycle n; data is sampled from the filtered data line in cycle n.
REQ-015 FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on falling edge with data 0 -> DATA with bit count 0; with data 1 -> stay IDLE, no pulse.
REQ-017 DATA: each falling edge shifts data in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: on falling edge, store the parity bit and compute odd parity over 8 data bits plus the parity bit -> STOP.
REQ-019 STOP: on falling edge -> IDLE; the byte is accepted only if parity is correct and the stop bit is 1.
REQ-020 Parity fail: parity_err pulses the cycle after the stop edge, the byte is discarded, and the pending prefix flags are cleared; parity failure has precedence over a stop-bit failure.
REQ-021 Stop bit 0 with correct parity: frame_err pulses the cycle after the stop edge, the byte is discarded, and the prefix flags are cleared.
REQ-022 An accepted 8'hE0 sets pending_ext and an accepted 8'hF0 sets pending_rel; neither pulses strobe.
REQ-023 Any other accepted byte, including 8'hE1, loads code from the byte and extended/released from the pending flags.
REQ-024 That load pulses strobe exactly one cycle, one cycle after the stop edge, and clears both pending flags in the same cycle.
REQ-025 code, extended and released hold their values until the next strobe.
REQ-026 A timeout counter clears on every falling edge and counts while not in IDLE.
REQ-027 When the counter reaches TIMEOUT_CYC the FSM returns to IDLE and discards the partial byte, without any pulse; pending prefix flags are kept.
REQ-028 A falling edge in the same cycle as the timeout is processed as an edge, and the timeout is not taken.
REQ-029 The FSM is never more than one edge per cycle; edges arriving while the strobe pulse is high are processed normally.

Reset
REQ-030 While reset_osd=0, all of the following are 0: synchronizer and filter state (filter output forced 1, idle line), FSM (IDLE), shift register, bit count, timeout counter, pending flags, code, extended, released, strobe, parity_err, frame_err, busy.
REQ-031 Reset assertion mid-frame abandons the frame; no pulse is produced after release until a new complete frame arrives.

Structure
REQ-032 Package lynx_ps2_pkg holds the FSM state enum, the constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_REL=8'hF0, and the default FILTER_LEN/TIMEOUT_CYC values.
REQ-033 Sub-module ps2_line_filter (synchronizer plus FILTER_LEN debounce, same clock and reset) is instantiated once per ps2 bit.

Verification
REQ-034 Frame 8'h1C, parity 0, stop 1 -> one strobe, code=1C, extended=0, released=0.
REQ-035 Frames F0, 1C -> exactly one strobe, code=1C, released=1, extended=0.
REQ-036 Frames E0, F0, 75 (parity 0) -> one strobe, code=75, extended=1, released=1; a following 1C gives code=1C with both flags 0.
REQ-037 Frame 1C with parity bit 1 -> parity_err pulse, no strobe, code unchanged.
REQ-038 Start bit plus 3 data bits, then idle TIMEOUT_CYC+10 cycles, then full 1C frame -> busy returns to 0 during the idle gap, then exactly one strobe with code=1C.
REQ-039 reset_osd pulsed low after bit 5 of a frame, then a full 1C frame -> no output during the reset, then one strobe with code=1C.

Source files
------------

// File: rtl/lynx_ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, prefix bytes
// and default timing parameters.
package lynx_ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0]  PS2_PREFIX_EXT      = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_REL      = 8'hF0;
  localparam int unsigned PS2_FILTER_LEN_DEF  = 4;
  localparam int unsigned PS2_TIMEOUT_CYC_DEF = 50000;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a debounce filter that accepts a new line
// level only after FILTER_LEN consecutive equal samples.
module ps2_line_filter
  import lynx_ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clock,
  input  logic reset_osd,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Reset to the idle (high) line level so no spurious edge follows release.
  always_ff @(posedge clock or negedge reset_osd) begin
    if (!reset_osd) begin
      sync <= '1;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver: filters the PS/2 lines, deframes 11-bit frames
// and folds E0/F0 prefixes into flags attached to the following scancode.
module ps2_kbd_rx
  import lynx_ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = PS2_FILTER_LEN_DEF,
  parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
  input  logic       clock,
  input  logic       reset_osd,
  input  logic [1:0] ps2,
  output logic [7:0] code,
  output logic       extended,
  output logic       released,
  output logic       strobe,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_e state, state_n;

  logic          clk_f, dat_f, clk_f_q, fall;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          pending_ext, pending_rel;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clock     (clock),
    .reset_osd (reset_osd),
    .din       (ps2[0]),
    .dout      (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clock     (clock),
    .reset_osd (reset_osd),
    .din       (ps2[1]),
    .dout      (dat_f)
  );

  assign fall        = clk_f_q & ~clk_f;
  assign timeout_hit = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC));
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clock or negedge reset_osd) begin
    if (!reset_osd) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // An edge always wins over a coincident timeout.
  always_comb begin
    state_n = state;
    if (fall) begin
      unique case (state)
        ST_IDLE:   if (!dat_f) state_n = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_n = ST_PARITY;
        ST_PARITY: state_n = ST_STOP;
        ST_STOP:   state_n = ST_IDLE;
        default:   state_n = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_osd) begin
    if (!reset_osd) begin
      clk_f_q     <= 1'b1;
      shreg       <= '0;
      bit_cnt     <= '0;
      par_ok      <= 1'b0;
      to_cnt      <= '0;
      pending_ext <= 1'b0;
      pending_rel <= 1'b0;
      code        <= '0;
      extended    <= 1'b0;
      released    <= 1'b0;
      strobe      <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      clk_f_q    <= clk_f;
      strobe     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (state == ST_IDLE || fall || timeout_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (fall) begin
        unique case (state)
          ST_IDLE: begin
            if (!dat_f) bit_cnt <= '0;
          end
          ST_DATA: begin
            shreg   <= {dat_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: begin
            par_ok <= ^{shreg, dat_f};
          end
          ST_STOP: begin
            if (!par_ok) begin
              parity_err  <= 1'b1;
              pending_ext <= 1'b0;
              pending_rel <= 1'b0;
            end else if (!dat_f) begin
              frame_err   <= 1'b1;
              pending_ext <= 1'b0;
              pending_rel <= 1'b0;
            end else if (shreg == PS2_PREFIX_EXT) begin
              pending_ext <= 1'b1;
            end else if (shreg == PS2_PREFIX_REL) begin
              pending_rel <= 1'b1;
            end else begin
              code        <= shreg;
              extended    <= pending_ext;
              released    <= pending_rel;
              strobe      <= 1'b1;
              pending_ext <= 1'b0;
              pending_rel <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (timeout_hit) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: directed PS/2 frames push expected events,
// a monitor pops and compares on every strobe/parity_err/frame_err pulse.
module tb_ps2_kbd_rx;

  localparam int unsigned TO   = 200;
  localparam int unsigned HALF = 20;

  logic       clock = 1'b0;
  logic       reset_osd = 1'b0;
  logic [1:0] ps2 = 2'b11;
  logic [7:0] code;
  logic       extended, released, strobe, parity_err, frame_err, busy;

  always #5 clock = ~clock;

  ps2_kbd_rx #(.FILTER_LEN(4), .TIMEOUT_CYC(TO)) dut (
    .clock      (clock),
    .reset_osd  (reset_osd),
    .ps2        (ps2),
    .code       (code),
    .extended   (extended),
    .released   (released),
    .strobe     (strobe),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct packed {
    logic [2:0] kind;   // 001 strobe, 010 parity_err, 100 frame_err
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (strobe || parity_err || frame_err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%b expected=none", {frame_err, parity_err, strobe});
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", {29'd0, frame_err, parity_err, strobe}, {29'd0, mon_e.kind});
        if (mon_e.kind == 3'b001) begin
          chk("code", {24'd0, code}, {24'd0, mon_e.code});
          chk("extended", {31'd0, extended}, {31'd0, mon_e.ext});
          chk("released", {31'd0, released}, {31'd0, mon_e.rel});
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ps2_bit(input logic b);
    ps2[1] = b;
    wait_cyc(HALF);
    ps2[0] = 1'b0;
    wait_cyc(HALF);
    ps2[0] = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stp);
    ps2[1] = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic exp_strobe(input logic [7:0] c, input logic e, input logic r);
    sb.push_back({3'b001, c, e, r});
  endtask

  task automatic exp_err(input logic [2:0] k);
    sb.push_back({k, 8'h00, 1'b0, 1'b0});
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) wait_cyc(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending expected=0", sb.size());
      sb.delete();
    end
    wait_cyc(10);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_cyc(5);
    chk("rst_code", {24'd0, code}, 32'h0);
    chk("rst_flags", {28'd0, extended, released, strobe, busy}, 32'h0);
    chk("rst_errs", {30'd0, parity_err, frame_err}, 32'h0);
    reset_osd = 1'b1;
    wait_cyc(20);

    // plain make code
    exp_strobe(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain();

    // break code
    send_frame(8'hF0, 1'b1, 1'b1);
    exp_strobe(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain();

    // extended break, then flags cleared for the next code
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    exp_strobe(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    exp_strobe(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain();

    // parity error: no strobe, code holds
    exp_err(3'b010);
    send_frame(8'h1C, 1'b1, 1'b1);
    drain();
    chk("code_hold", {24'd0, code}, 32'h1C);

    // parity error clears a pending prefix; parity wins over bad stop bit
    send_frame(8'hE0, 1'b0, 1'b1);
    exp_err(3'b010);
    send_frame(8'h1C, 1'b1, 1'b0);
    exp_strobe(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain();

    // frame error clears a pending prefix
    send_frame(8'hF0, 1'b1, 1'b1);
    exp_err(3'b100);
    send_frame(8'h1C, 1'b0, 1'b0);
    exp_strobe(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain();

    // E1 is an ordinary code, not a prefix
    exp_strobe(8'hE1, 1'b0, 1'b0);
    send_frame(8'hE1, 1'b1, 1'b1);
    drain();

    // timeout abandons a partial frame
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    wait_cyc(5);
    chk("busy_partial", {31'd0, busy}, 32'h1);
    wait_cyc(TO + 10);
    chk("busy_timeout", {31'd0, busy}, 32'h0);
    exp_strobe(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain();

    // timeout keeps a pending prefix
    send_frame(8'hE0, 1'b0, 1'b1);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    wait_cyc(TO + 10 + HALF);
    chk("busy_timeout2", {31'd0, busy}, 32'h0);
    exp_strobe(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain();

    // reset mid-frame clears outputs and the pending prefix
    send_frame(8'hE0, 1'b0, 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    wait_cyc(5);
    reset_osd = 1'b0;
    wait_cyc(3);
    chk("rst_mid_busy", {31'd0, busy}, 32'h0);
    chk("rst_mid_code", {24'd0, code}, 32'h0);
    ps2[1] = 1'b1;
    wait_cyc(20);
    reset_osd = 1'b1;
    wait_cyc(20);
    exp_strobe(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain();

    wait_cyc(50);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
